// File: rtl/bram_port_arb.sv
// Two-requester arbiter for one synchronous BRAM port, with bounded lock ownership.
// Define BRAM_ARB_RR_EN to resolve idle ties round-robin instead of fixed requester-0 priority.
module bram_port_arb #(
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic        we0,
    input  logic        we1,
    input  logic [9:0]  addr0,
    input  logic [9:0]  addr1,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    output logic        ack0,
    output logic        ack1,
    output logic        rv0,
    output logic        rv1,
    output logic [31:0] rd,
    output logic        ram_en,
    output logic        ram_we,
    output logic [9:0]  ram_a,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd
);

    // state | meaning
    // IDLE  | no owner; ties resolved by priority rule
    // OWN0  | requester 0 holds the lock; requester 1 waits
    // OWN1  | requester 1 holds the lock; requester 0 waits
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    state_t      state_q, state_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic        rv0_q, rv0_d;
    logic        rv1_q, rv1_d;
    logic        gnt0, gnt1;
    logic        tie_to1;

`ifdef BRAM_ARB_RR_EN
    logic        ptr_q, ptr_d;
    assign tie_to1 = ptr_q;
`else
    assign tie_to1 = 1'b0;
`endif

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
`ifdef BRAM_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || !tie_to1)) begin
                    gnt0 = 1'b1;
                end else if (req1) begin
                    gnt1 = 1'b1;
                end
                if (gnt0 && lock0) begin
                    state_d    = OWN0;
                    lock_cnt_d = 8'd1;
                end else if (gnt1 && lock1) begin
                    state_d    = OWN1;
                    lock_cnt_d = 8'd1;
                end
`ifdef BRAM_ARB_RR_EN
                if (gnt0) begin
                    ptr_d = 1'b1;
                end else if (gnt1) begin
                    ptr_d = 1'b0;
                end
`endif
            end
            OWN0: begin
                if (!req0) begin
                    state_d    = IDLE;
                    lock_cnt_d = 8'd0;
                end else if (lock_cnt_q >= MAX_LOCK_C && req1) begin
                    // Owner has used up its quota: the waiter gets this cycle.
                    gnt1 = 1'b1;
                    if (lock1) begin
                        state_d    = OWN1;
                        lock_cnt_d = 8'd1;
                    end else begin
                        state_d    = IDLE;
                        lock_cnt_d = 8'd0;
                    end
                end else begin
                    gnt0 = 1'b1;
                    if (!lock0) begin
                        state_d    = IDLE;
                        lock_cnt_d = 8'd0;
                    end else if (req1 && lock_cnt_q < MAX_LOCK_C) begin
                        lock_cnt_d = lock_cnt_q + 8'd1;
                    end
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_d    = IDLE;
                    lock_cnt_d = 8'd0;
                end else if (lock_cnt_q >= MAX_LOCK_C && req0) begin
                    gnt0 = 1'b1;
                    if (lock0) begin
                        state_d    = OWN0;
                        lock_cnt_d = 8'd1;
                    end else begin
                        state_d    = IDLE;
                        lock_cnt_d = 8'd0;
                    end
                end else begin
                    gnt1 = 1'b1;
                    if (!lock1) begin
                        state_d    = IDLE;
                        lock_cnt_d = 8'd0;
                    end else if (req0 && lock_cnt_q < MAX_LOCK_C) begin
                        lock_cnt_d = lock_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = 8'd0;
            end
        endcase
    end

    // Grants are masked by reset so nothing reaches the RAM while rst_n is low.
    assign ack0   = gnt0 & rst_n;
    assign ack1   = gnt1 & rst_n;
    assign ram_en = ack0 | ack1;

    always_comb begin
        ram_we = 1'b0;
        ram_a  = 10'd0;
        ram_wd = 32'd0;
        if (ack0) begin
            ram_we = we0;
            ram_a  = addr0;
            ram_wd = wd0;
        end else if (ack1) begin
            ram_we = we1;
            ram_a  = addr1;
            ram_wd = wd1;
        end
    end

    assign rv0_d = ack0 & ~we0;
    assign rv1_d = ack1 & ~we1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_cnt_q <= 8'd0;
            rv0_q      <= 1'b0;
            rv1_q      <= 1'b0;
`ifdef BRAM_ARB_RR_EN
            ptr_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            rv0_q      <= rv0_d;
            rv1_q      <= rv1_d;
`ifdef BRAM_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign rv0 = rv0_q;
    assign rv1 = rv1_q;
    assign rd  = ram_rd;

endmodule
